// File: rtl/nios_system_pio_in_capture.sv
// Avalon-MM parallel input port with synchroniser, edge capture and optional irq.
// Define PIO_IN_CAPTURE_IRQ_EN to build the interrupt mask register and irq output.
module nios_system_pio_in_capture #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [2:0]       warm_q, warm_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask;
  logic             wr_en;
  logic             det_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

`ifdef PIO_IN_CAPTURE_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && address == 2'd2)
      mask_d = writedata[WIDTH-1:0];
    irq_d = |(edge_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask = mask_q;
  assign irq  = irq_q;
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
    cur    = sync_q[SYNC_STAGES-1];
    prev_d = cur;

    case (EDGE_TYPE)
      0:       det = cur & ~prev_q;
      1:       det = ~cur & prev_q;
      default: det = cur ^ prev_q;
    endcase

    // Hold off detection until the synchroniser and prev_q hold real data.
    det_en = (warm_q == WARM_MAX);
    warm_d = det_en ? warm_q : warm_q + 3'd1;

    wr_en = chipselect & ~write_n;
    clr   = '0;
    if (wr_en && address == 2'd3)
      clr = writedata[WIDTH-1:0];

    // A fresh edge beats a same-cycle clear.
    edge_d = (edge_q & ~clr) | (det_en ? det : '0);

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = cur;
      2'd2:    readdata_d[WIDTH-1:0] = mask;
      2'd3:    readdata_d[WIDTH-1:0] = edge_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev_q     <= '0;
      edge_q     <= '0;
      warm_q     <= '0;
      readdata_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_d[i];
      prev_q     <= prev_d;
      edge_q     <= edge_d;
      warm_q     <= warm_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_nios_system_pio_in_capture.sv
// Directed bench for nios_system_pio_in_capture: rising-edge and any-edge instances.
module tb_nios_system_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [7:0]  in_port_any;
  logic [31:0] readdata;
  logic [31:0] readdata_any;
  logic        irq;
  logic        irq_any;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nios_system_pio_in_capture #(
    .WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  nios_system_pio_in_capture #(
    .WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)
  ) dut_any (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port_any),
    .readdata(readdata_any), .irq(irq_any)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    address    = 2'd3;
  endtask

  initial begin
    reset       = 1'b1;
    address     = 2'd3;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    in_port     = 8'hFF;
    in_port_any = 8'h00;

    tick(3);
    chk("rst_rd", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("warm_ec", readdata, 32'h0);
      chk("warm_irq", {31'b0, irq}, 32'h0);
    end
    address = 2'd0;
    tick();
    chk("data_rd", readdata, 32'h000000FF);
    chk("data_any", readdata_any, 32'h0);

    // Falling edge is ignored in rising mode; then bit 3 rises.
    address = 2'd3;
    in_port = 8'hF7;
    tick(4);
    chk("fall_ign", readdata, 32'h0);
    in_port = 8'hFF;
    tick(3);
    chk("rise_lat", readdata, 32'h0);
    tick();
    chk("rise_cap", readdata, 32'h00000008);

    wr(2'd3, 32'h1);
    tick();
    chk("clr_other", readdata, 32'h00000008);
    wr(2'd3, 32'h8);
    tick();
    chk("clr_bit3", readdata, 32'h0);

    // Capture edge lands on the same edge as the clear write.
    in_port = 8'hF7;
    tick(4);
    in_port = 8'hFF;
    tick(2);
    wr(2'd3, 32'h8);
    tick();
    chk("set_wins", readdata, 32'h00000008);

    wr(2'd0, 32'hFFFFFFFF);
    wr(2'd1, 32'hFFFFFFFF);
    tick();
    chk("ro_wr", readdata, 32'h00000008);
    address = 2'd1;
    tick();
    chk("rsvd_rd", readdata, 32'h0);
    address = 2'd3;

`ifdef PIO_IN_CAPTURE_IRQ_EN
    wr(2'd3, 32'h8);
    wr(2'd2, 32'h8);
    address = 2'd2;
    tick();
    chk("mask_rd", readdata, 32'h00000008);
    address = 2'd3;
    in_port = 8'hF7;
    tick(4);
    in_port = 8'hFF;
    tick(3);
    chk("irq_pre", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'b0, irq}, 32'h1);
    chk("irq_ec", readdata, 32'h00000008);
    wr(2'd3, 32'h8);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    tick();
    chk("irq_clr", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h0);
    in_port = 8'hF7;
    tick(4);
    in_port = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("irq_masked", {31'b0, irq}, 32'h0);
    end
    chk("masked_ec", readdata, 32'h00000008);
    wr(2'd3, 32'h8);
`else
    wr(2'd2, 32'h8);
    address = 2'd2;
    tick();
    chk("nomask_rd", readdata, 32'h0);
    chk("noirq", {31'b0, irq}, 32'h0);
    address = 2'd3;
    wr(2'd3, 32'h8);
`endif

    // Any-edge: 5-cycle pulse on bit 0, cleared between transitions.
    in_port_any = 8'h01;
    tick(3);
    chk("any_lat", readdata_any, 32'h0);
    tick();
    chk("any_rise", readdata_any, 32'h1);
    wr(2'd3, 32'h1);
    in_port_any = 8'h00;
    tick();
    chk("any_clr", readdata_any, 32'h0);
    tick(2);
    chk("any_flat", readdata_any, 32'h0);
    tick();
    chk("any_fall", readdata_any, 32'h1);

    // Reset mid-operation with a concurrent mask write.
    in_port = 8'hF7;
    tick(4);
    in_port = 8'hFF;
    tick(4);
    chk("pre_rst", readdata, 32'h00000008);
    reset      = 1'b1;
    address    = 2'd2;
    writedata  = 32'hFF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chk("mid_rst_rd", readdata, 32'h0);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd3;
    tick();
    chk("post_rst_ec", readdata, 32'h0);
    address = 2'd2;
    tick();
    chk("post_rst_mask", readdata, 32'h0);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);
    address = 2'd3;
    tick(4);
    chk("post_rst_warm", readdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_pio_in_capture.md
NIOS_SYSTEM_PIO_IN_CAPTURE -- requirements
Module: nios_system_pio_in_capture

Interface
REQ-001 Parameter WIDTH, default 8, meaning input port width, legal 1..32.
REQ-002 Parameter EDGE_TYPE, default 0, meaning edge captured: 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter SYNC_STAGES, default 2, meaning synchroniser depth, legal 2..4.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk, input, 1 bit: sole clock; all state changes on its rising edge.
- reset, input, 1 bit: synchronous, active-high reset.
- address, input, 2 bits: Avalon-MM word address.
- chipselect, input, 1 bit: slave select.
- write_n, input, 1 bit: active-low write strobe; qualified by chipselect.
- writedata, input, 32 bits: write data.
- in_port, input, WIDTH bits: asynchronous external inputs.
- readdata, output, 32 bits: registered read data, zero-extended above WIDTH.
- irq, output, 1 bit: level interrupt; present only per REQ-020.

Function
REQ-005 in_port SHALL pass through SYNC_STAGES flops before any use; sync_q denotes the last stage and prev_q holds sync_q delayed one cycle.
REQ-006 Address map SHALL be:
- 0 = data (sync_q, read-only).
- 1 = reserved; reads 0, writes ignored.
- 2 = interruptmask (RW, WIDTH bits).
- 3 = edgecapture (read; write-1-to-clear per bit).
REQ-007 readdata SHALL update every cycle from the address-selected register, giving one-cycle read latency; chipselect is not required for reads, and bits above WIDTH read 0.
REQ-008 Edge detect per bit:
- rising = sync_q & ~prev_q.
- falling = ~sync_q & prev_q.
- any = sync_q ^ prev_q.
- EDGE_TYPE selects which is used.
REQ-009 A detected edge SHALL set the corresponding edgecapture bit on the next clock edge; the bit is sticky until cleared.
REQ-010 A write with chipselect=1, write_n=0, address=3 SHALL clear each edgecapture bit whose writedata bit is 1; other bits are unchanged.
REQ-011 If a set and a clear of the same bit occur in one cycle, the set SHALL win.
REQ-012 A write to address 2 SHALL load interruptmask from writedata[WIDTH-1:0] on the next clock edge.
REQ-013 Writes to address 0 or 1 SHALL have no effect.
REQ-014 After reset deassertion, a warm-up counter SHALL suppress edge detection for SYNC_STAGES+1 cycles so the synchroniser fill is not captured as an edge; once the counter saturates, detection is enabled permanently until the next reset.
REQ-015 Latency from an in_port change to the edgecapture bit set SHALL be SYNC_STAGES+1 cycles; to a visible readdata change it SHALL be SYNC_STAGES+2 cycles.

Reset
REQ-016 While reset=1, on each clock edge:
- readdata, edgecapture, interruptmask, all synchroniser flops, prev_q and the warm-up counter SHALL go to 0.
- irq SHALL be 0.
REQ-017 Reset asserted mid-operation SHALL discard pending captures and ignore any write in the same cycle.

Configuration
REQ-018 Macro PIO_IN_CAPTURE_IRQ_EN controls the interrupt logic.
REQ-019 With PIO_IN_CAPTURE_IRQ_EN defined, irq SHALL be registered and equal to |(edgecapture & interruptmask), lagging edgecapture by one cycle.
REQ-020 Without PIO_IN_CAPTURE_IRQ_EN:
- irq SHALL be tied to 0.
- The interruptmask register SHALL not exist; address 2 reads 0 and writes to it are ignored.
- Edge capture SHALL still operate.

Verification
REQ-021 Reset hold: reset=1 for 3 cycles with in_port=8'hFF, then release -> edgecapture stays 0 and no irq through warm-up; reading address 0 returns 32'h000000FF.
REQ-022 Rising capture: EDGE_TYPE=0, drive in_port bit 3 from 0 to 1 -> edgecapture=8'h08 after 3 cycles; reading address 3 returns 32'h00000008.
REQ-023 Clear: write 32'h00000008 to address 3 -> edgecapture=0 next cycle; writing 32'h00000001 instead leaves 8'h08.
REQ-024 Set-wins collision: a bit-3 edge lands in the same cycle as a write-1-to-clear of bit 3 -> edgecapture bit 3 remains 1.
REQ-025 IRQ (macro defined): write interruptmask=8'h08, then a bit-3 edge -> irq=1 one cycle after the capture; clearing the bit -> irq=0 one cycle later; with mask 8'h00, irq stays 0.
REQ-026 Any-edge mode: EDGE_TYPE=2, pulse bit 0 high for 5 cycles -> bit 0 is set on both transitions; with a clear between the transitions, it is set again at the falling transition.
